div_unit: RTL

- Iterative 32-bit radix-2 restoring divider serving the EX stage for DIV/DIVU.
- EX drives operands and holds start_i high; the divider returns {remainder, quotient} with ready_o.
- EX writes the result to HI/LO: HI = remainder, LO = quotient.
- Multi-cycle: EX requests a pipeline stall while start_i=1 and ready_o=0.

---
 rtl/div_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH iterations; divide-by-zero short-circuits to zero.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   quot, quot_n;
  logic [WIDTH:0]     rem, rem_n;
  logic [WIDTH-1:0]   divisor, divisor_n;
  logic               s1, s1_n, s2, s2_n;
  logic [2*WIDTH-1:0] result_n;
  logic               ready_n;

  logic [WIDTH:0]     rem_shift, rem_diff, rem_iter;
  logic [WIDTH-1:0]   quot_iter;
  logic               fits;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return '0 - x;
  endfunction

  // Two's complement magnitude; the most negative value maps onto itself, which is
  // exactly the unsigned magnitude needed by the restoring loop.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

  always_comb begin
    rem_shift = {rem[WIDTH-1:0], quot[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, divisor};
    fits      = (rem_shift >= {1'b0, divisor});
    rem_iter  = fits ? rem_diff : rem_shift;
    quot_iter = {quot[WIDTH-2:0], fits};
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    quot_n    = quot;
    rem_n     = rem;
    divisor_n = divisor;
    s1_n      = s1;
    s2_n      = s2;
    result_n  = result_o;
    ready_n   = ready_o;
    case (state)
      FREE: begin
        ready_n  = 1'b0;
        result_n = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_n = BYZERO;
          end else begin
            state_n = ON;
            rem_n   = '0;
            cnt_n   = '0;
            if (signed_div_i) begin
              quot_n    = magnitude(opdata1_i);
              divisor_n = magnitude(opdata2_i);
              s1_n      = opdata1_i[WIDTH-1];
              s2_n      = opdata2_i[WIDTH-1];
            end else begin
              quot_n    = opdata1_i;
              divisor_n = opdata2_i;
              s1_n      = 1'b0;
              s2_n      = 1'b0;
            end
          end
        end
      end
      BYZERO: begin
        state_n  = END;
        result_n = '0;
        ready_n  = 1'b1;
      end
      ON: begin
        // Losing start_i mid-division means EX no longer wants the result.
        if (annul_i || !start_i) begin
          state_n  = FREE;
          ready_n  = 1'b0;
          result_n = '0;
          cnt_n    = '0;
        end else begin
          rem_n  = rem_iter;
          quot_n = quot_iter;
          cnt_n  = cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            result_n = {s1 ? negate(rem_iter[WIDTH-1:0]) : rem_iter[WIDTH-1:0],
                        (s1 ^ s2) ? negate(quot_iter) : quot_iter};
            ready_n  = 1'b1;
            state_n  = END;
          end
        end
      end
      END: begin
        if (!start_i) begin
          state_n  = FREE;
          ready_n  = 1'b0;
          result_n = '0;
        end
      end
      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= '0;
      quot     <= '0;
      rem      <= '0;
      divisor  <= '0;
      s1       <= 1'b0;
      s2       <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      quot     <= quot_n;
      rem      <= rem_n;
      divisor  <= divisor_n;
      s1       <= s1_n;
      s2       <= s2_n;
      result_o <= result_n;
      ready_o  <= ready_n;
    end
  end

endmodule
